// File: rtl/mesm6_mem_arbiter.sv
// mesm6_mem_arbiter: shares one memory port between the CPU instruction bus
// (ibus) and data bus (dbus). Simultaneous requests alternate between the two
// buses, starting with dbus after reset. Every access is a single registered
// memory transaction, followed by a one-cycle done pulse on the granted bus.
//
// Optional feature: define MESM6_ARB_IFETCH_CACHE_EN to add a one-entry
// instruction-word buffer. A repeated fetch of the same address is then
// answered without a memory access. A dbus write to that address invalidates
// the buffer.
module mesm6_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction bus
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  // data bus
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  // memory port
  output logic        mem_read,
  output logic        mem_write,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;
  typedef enum logic {GNT_IBUS, GNT_DBUS} grant_t;

  state_t r_state;
  state_t w_next_state;
  grant_t r_last_grant;
  logic   r_resp_dbus;   // which bus receives the done pulse in RESP

  logic   w_dbus_req;
  logic   w_pick_dbus;
  logic   w_pick_ibus;
  logic   w_hit;
  logic   w_acc_done;

`ifdef MESM6_ARB_IFETCH_CACHE_EN
  logic        r_ic_valid;
  logic [14:0] r_ic_tag;
  logic [47:0] r_ic_data;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Arbitration decision and next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. This
    // keeps each path fully assigned and prevents inferred latches.
    w_next_state = r_state;
    w_dbus_req   = dbus_read | dbus_write;
    w_pick_dbus  = 1'b0;
    w_pick_ibus  = 1'b0;
    w_hit        = 1'b0;
    w_acc_done   = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, the bus that did not win last time gets the grant.
        w_pick_dbus = w_dbus_req & (~ibus_fetch | (r_last_grant == GNT_IBUS));
        w_pick_ibus = ibus_fetch & ~w_pick_dbus;
`ifdef MESM6_ARB_IFETCH_CACHE_EN
        w_hit       = w_pick_ibus & r_ic_valid & (r_ic_tag == ibus_addr);
`endif
        if (w_pick_dbus)      w_next_state = D_ACC;
        else if (w_hit)       w_next_state = RESP;
        else if (w_pick_ibus) w_next_state = I_ACC;
      end
      I_ACC, D_ACC: begin
        // The access completes even if the requester has already dropped its request.
        if (mem_ready) begin
          w_acc_done   = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered memory strobes, address/data latches, grant history and read data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GNT_IBUS;
      r_resp_dbus  <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ibus_input   <= '0;
      dbus_input   <= '0;
`ifdef MESM6_ARB_IFETCH_CACHE_EN
      // NOTE: only the valid bit needs a reset to keep the buffer correct.
      // Tag and data are reset as well so that the outputs are free of X
      // after reset.
      r_ic_valid   <= 1'b0;
      r_ic_tag     <= '0;
      r_ic_data    <= '0;
`endif
    end else begin
      if (r_state == IDLE) begin
        if (w_pick_dbus) begin
          // A request with both read and write high is treated as a write.
          mem_write    <= dbus_write;
          mem_read     <= ~dbus_write;
          mem_addr     <= dbus_addr;
          mem_wdata    <= dbus_output;
          r_last_grant <= GNT_DBUS;
          r_resp_dbus  <= 1'b1;
        end else if (w_pick_ibus) begin
          r_resp_dbus  <= 1'b0;
`ifdef MESM6_ARB_IFETCH_CACHE_EN
          if (w_hit) begin
            ibus_input   <= r_ic_data;
          end else begin
            mem_read     <= 1'b1;
            mem_addr     <= ibus_addr;
            r_last_grant <= GNT_IBUS;
          end
`else
          mem_read     <= 1'b1;
          mem_addr     <= ibus_addr;
          r_last_grant <= GNT_IBUS;
`endif
        end
      end

      if (w_acc_done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (r_state == I_ACC) begin
          ibus_input <= mem_rdata;
`ifdef MESM6_ARB_IFETCH_CACHE_EN
          r_ic_valid <= 1'b1;
          r_ic_tag   <= mem_addr;
          r_ic_data  <= mem_rdata;
`endif
        end else begin
          // On a write, the memory's read data is not meaningful, so dbus_input is kept.
          if (!mem_write) dbus_input <= mem_rdata;
`ifdef MESM6_ARB_IFETCH_CACHE_EN
          if (mem_write && (mem_addr == r_ic_tag)) r_ic_valid <= 1'b0;
`endif
        end
      end
    end
  end

  // One-cycle done pulse, decoded from the registered state.
  always_comb begin
    ibus_done = (r_state == RESP) & ~r_resp_dbus;
    dbus_done = (r_state == RESP) &  r_resp_dbus;
  end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Self-checking bench for mesm6_mem_arbiter: table-driven single transactions
// plus hand-written sequences for tie-break, reset and buffer behaviour.
// Cache expectations follow MESM6_ARB_IFETCH_CACHE_EN when it is defined.
module tb_mesm6_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read;
  logic        dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_read;
  logic        mem_write;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  // Model of the captured read data.
  logic [47:0] exp_i = '0;
  logic [47:0] exp_d = '0;

  typedef struct {
    bit          is_ibus;
    bit          rd;
    bit          wr;
    logic [14:0] addr;
    logic [47:0] wdata;
    logic [47:0] rdata;
    int          waits;
    int          exp_lat;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[6];

  mesm6_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
    .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    ibus_fetch = 1'b0;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
  endtask

  function automatic vec_t mk(input bit is_ibus, input bit rd, input bit wr,
                              input logic [14:0] addr, input logic [47:0] wdata,
                              input logic [47:0] rdata, input int waits,
                              input int exp_lat, input int exp_strobes);
    vec_t v;
    v.is_ibus = is_ibus; v.rd = rd; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.exp_lat = exp_lat; v.exp_strobes = exp_strobes;
    return v;
  endfunction

  // Drive one request for a single sampling edge and act as the memory.
  // Then check latency, strobes, captured data and the done pulse width.
  task automatic run_txn(input vec_t v, input string tag);
    int lat = -1;
    int strobes = 0;
    bit addr_ok = 1'b1;
    bit kind_ok = 1'b1;
    bit wrong_done = 1'b0;
    ibus_fetch  = v.is_ibus;
    ibus_addr   = v.addr;
    dbus_read   = v.rd;
    dbus_write  = v.wr;
    dbus_addr   = v.addr;
    dbus_output = v.wdata;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      clear_reqs();
      if (mem_read || mem_write) begin
        strobes++;
        if (mem_addr !== v.addr) addr_ok = 1'b0;
        if (!v.is_ibus && v.wr && mem_wdata !== v.wdata) addr_ok = 1'b0;
        if (mem_write !== (!v.is_ibus && v.wr) || mem_read !== (v.is_ibus || !v.wr)) kind_ok = 1'b0;
        if (strobes == v.waits + 1) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 48'hBAD0_BAD0_BAD0;
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (ibus_done || dbus_done) begin
        if (ibus_done !== v.is_ibus || dbus_done !== !v.is_ibus) wrong_done = 1'b1;
        lat = cyc;
        break;
      end
    end
    mem_ready = 1'b0;
    if (v.is_ibus) exp_i = v.rdata;
    else if (!v.wr) exp_d = v.rdata;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " strobe cycles"}, strobes, v.exp_strobes);
    check({tag, " addr/wdata stable"}, addr_ok, 1);
    check({tag, " read/write kind"}, kind_ok, 1);
    check({tag, " correct done"}, wrong_done, 0);
    check({tag, " ibus_input"}, ibus_input, exp_i);
    check({tag, " dbus_input"}, dbus_input, exp_d);
    @(posedge clk); #1;
    check({tag, " done width"}, {ibus_done, dbus_done}, 2'b00);
  endtask

  initial begin
    logic [5:0]  dmask;
    logic [5:0]  imask;
    logic [14:0] acc_addr [6];
    bit          flag;

    reset = 1'b1;
    clear_reqs();
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("reset strobes", {mem_read, mem_write}, 2'b00);
    check("reset done", {ibus_done, dbus_done}, 2'b00);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset ibus_input", ibus_input, 0);
    check("reset dbus_input", dbus_input, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Table of single transactions: first one issued right at reset release
    vecs[0] = mk(1, 0, 0, 15'h0010, 48'h0,            48'h1234_5678_9ABC, 0, 2, 1);
    vecs[1] = mk(0, 1, 0, 15'h0100, 48'h0,            48'hCAFE_F00D_1234, 1, 3, 2);
    vecs[2] = mk(0, 0, 1, 15'h0005, 48'h0000_0000_0007, 48'hDEAD_BEEF_0000, 3, 5, 4);
    vecs[3] = mk(1, 0, 0, 15'h7FFF, 48'h0,            48'hFFFF_FFFF_FFFF, 2, 4, 3);
    vecs[4] = mk(0, 1, 1, 15'h0001, 48'h0000_AAAA_5555, 48'h1111_1111_1111, 0, 2, 1);
    vecs[5] = mk(0, 1, 0, 15'h0000, 48'h0,            48'h0000_0000_0000, 0, 2, 1);
    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // mem_ready while idle must be ignored
    flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c < 2);
      mem_rdata = 48'h7777_7777_7777;
      @(posedge clk); #1;
      if (mem_read || mem_write || ibus_done || dbus_done) flag = 1'b1;
    end
    mem_ready = 1'b0;
    check("ready in idle ignored", flag, 0);
    check("ready in idle dbus_input", dbus_input, exp_d);

    // Asynchronous reset clears the captured data
    reset = 1'b0; #1;
    check("async reset ibus_input", ibus_input, 0);
    check("async reset mem_wdata", mem_wdata, 0);
    exp_i = '0; exp_d = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Tie after reset: dbus first, then ibus, both requests held
    dbus_read = 1'b1; dbus_addr = 15'h0200;
    ibus_fetch = 1'b1; ibus_addr = 15'h0300;
    dmask = '0; imask = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      acc_addr[c-1] = (mem_read || mem_write) ? mem_addr : 15'h7ABC;
      if (mem_read || mem_write) begin
        mem_ready = 1'b1;
        mem_rdata = {33'b0, mem_addr};
      end else begin
        mem_ready = 1'b0;
      end
      dmask[c-1] = dbus_done;
      imask[c-1] = ibus_done;
    end
    clear_reqs();
    mem_ready = 1'b0;
    check("tie first access addr", acc_addr[0], 15'h0200);
    check("tie second access addr", acc_addr[3], 15'h0300);
    check("tie dbus_done pattern", dmask, 6'b000010);
    check("tie ibus_done pattern", imask, 6'b010000);
    check("tie dbus_input", dbus_input, 48'h200);
    check("tie ibus_input", ibus_input, 48'h300);
    exp_d = 48'h200; exp_i = 48'h300;
    @(posedge clk); #1;

    // Reset during a write access: strobe drops at once, no done pulse
    dbus_write = 1'b1; dbus_addr = 15'h0033; dbus_output = 48'h0A0B_0C0D_0E0F;
    @(posedge clk); #1;
    clear_reqs();
    check("mid-reset strobe before", mem_write, 1);
    #2 reset = 1'b0;
    #1;
    check("mid-reset mem_write dropped", mem_write, 0);
    check("mid-reset mem_addr cleared", mem_addr, 0);
    flag = dbus_done;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (dbus_done || ibus_done) flag = 1'b1;
    end
    reset = 1'b1;
    exp_i = '0; exp_d = '0;
    @(posedge clk); #1;
    if (dbus_done || ibus_done) flag = 1'b1;
    check("mid-reset no done", flag, 0);
    check("mid-reset idle after release", {mem_read, mem_write}, 2'b00);
    run_txn(mk(0, 1, 0, 15'h0044, 48'h0, 48'h0000_0000_BEEF, 0, 2, 1), "post-reset");

    // Repeated fetch, then write to same address, then fetch again
    run_txn(mk(1, 0, 0, 15'h0020, 48'h0, 48'h0A0A_0B0B_0C0C, 0, 2, 1), "fetch1");
`ifdef MESM6_ARB_IFETCH_CACHE_EN
    run_txn(mk(1, 0, 0, 15'h0020, 48'h0, 48'h0A0A_0B0B_0C0C, 0, 1, 0), "fetch2");
`else
    run_txn(mk(1, 0, 0, 15'h0020, 48'h0, 48'h0A0A_0B0B_0C0C, 0, 2, 1), "fetch2");
`endif
    run_txn(mk(0, 0, 1, 15'h0020, 48'h0000_0000_0055, 48'h9999_9999_9999, 0, 2, 1), "write20");
    run_txn(mk(1, 0, 0, 15'h0020, 48'h0, 48'h0D0D_0E0E_0F0F, 1, 3, 2), "fetch3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
MESM6_MEM_ARBITER -- requirements
Module: mesm6_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have CPU instruction-bus ports: ibus_fetch in 1; ibus_addr in 15; ibus_input out 48; ibus_done out 1.
REQ-003 SHALL have CPU data-bus ports: dbus_read in 1; dbus_write in 1; dbus_addr in 15; dbus_output in 48 (write data); dbus_input out 48; dbus_done out 1.
REQ-004 SHALL have memory-port ports: mem_read out 1; mem_write out 1; mem_addr out 15; mem_wdata out 48; mem_rdata in 48; mem_ready in 1 (one-cycle completion pulse).
REQ-005 SHALL have no parameters.

Function
REQ-006 SHALL share the single memory port between ibus and dbus using FSM states IDLE, I_ACC, D_ACC, RESP.
REQ-007 IDLE: dbus request (dbus_read|dbus_write) only -> D_ACC; ibus_fetch only -> I_ACC; both -> grant opposite of last_grant; none -> IDLE.
REQ-008 last_grant SHALL update on every entry to I_ACC or D_ACC.
REQ-009 last_grant SHALL reset to IBUS, so the first tie goes to dbus.
REQ-010 I_ACC: mem_read=1, mem_addr=ibus_addr latched at grant; remain until mem_ready, then -> RESP.
REQ-011 D_ACC: mem_write=1 if dbus_write at grant, else mem_read=1; mem_addr/mem_wdata = dbus_addr/dbus_output latched at grant; remain until mem_ready, then -> RESP.
REQ-012 dbus_read and dbus_write both high SHALL be treated as write.
REQ-013 mem_read, mem_write, mem_addr, mem_wdata SHALL be registered and stable for the entire access.
REQ-014 On mem_ready in an ACC state, mem_rdata SHALL be captured into ibus_input or dbus_input (per granted bus); write access leaves dbus_input unchanged.
REQ-015 RESP: exactly one done output (ibus_done or dbus_done) high for exactly one cycle; -> IDLE unconditionally.
REQ-016 Captured data SHALL remain valid until the next capture into the same register.
REQ-017 Latency with zero-wait memory (mem_ready in first ACC cycle): request seen in IDLE at cycle N -> done at N+2.
REQ-018 Each additional wait cycle of mem_ready SHALL add one cycle.
REQ-019 A request held high through the RESP cycle SHALL be treated as a new request when sampled in IDLE.
REQ-020 mem_ready in IDLE or RESP SHALL be ignored.
REQ-021 A request dropped during ACC SHALL NOT abort the access; the access completes and done still pulses.

Reset
REQ-022 reset low SHALL asynchronously force state=IDLE, last_grant=IBUS, all strobes and done=0, mem_addr=0, mem_wdata=0, ibus_input=0, dbus_input=0.
REQ-023 Reset mid-access SHALL drop mem_read/mem_write immediately with no done pulse.
REQ-024 After reset release, the first request SHALL be sampled on the first rising clk edge.

Configuration
REQ-025 Macro MESM6_ARB_IFETCH_CACHE_EN defined: one-entry instruction-word buffer (valid bit, 15-bit tag, 48-bit data), filled on every I_ACC completion.
REQ-026 With the macro: ibus-granted IDLE cycle with valid and tag==ibus_addr -> RESP directly (no memory access), ibus_input=buffer data, done at N+1.
REQ-027 With the macro: a D_ACC write whose address equals the tag SHALL clear valid; reset SHALL clear valid.
REQ-028 Macro undefined: no buffer; every fetch accesses memory per REQ-010.

Verification
REQ-029 Fetch 0x0010, memory returns 0x123456789ABC with zero wait -> mem_read at N+1 only, ibus_done at N+2, ibus_input=0x123456789ABC.
REQ-030 dbus_read and ibus_fetch both high after reset -> dbus served first; ibus granted in the next IDLE; two done pulses, each exactly one cycle.
REQ-031 Write 0x000000000007 to 0x0005 with mem_ready delayed 3 cycles -> mem_write high 4 cycles, addr/wdata stable, dbus_done one cycle, dbus_input unchanged.
REQ-032 Reset asserted during D_ACC -> mem_write=0 within the same cycle, no dbus_done, IDLE after release.
REQ-033 With MESM6_ARB_IFETCH_CACHE_EN: fetch 0x0020 twice -> second fetch causes no mem_read and gives ibus_done at N+1; write 0x0020 then fetch again -> memory read occurs.
